// File: rtl/passcode_pkg.sv
// Shared types and width helpers for the passcode lock.
package passcode_pkg;

    typedef enum logic [1:0] {
        S_ENTRY    = 2'd0,
        S_UNLOCKED = 2'd1,
        S_PROGRAM  = 2'd2,
        S_LOCKOUT  = 2'd3
    } lock_state_t;

    // Width of a counter that must hold every value 0..max_value without wrapping.
    function automatic int count_w(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int digit_count_w(input int code_len);
        return count_w(code_len);
    endfunction

    function automatic int attempts_w(input int max_attempts);
        return count_w(max_attempts);
    endfunction

endpackage

// File: rtl/btn_one_shot.sv
// Turns a raw active-low push button into a single-cycle press strobe,
// one strobe per low period regardless of how long the button is held.
module btn_one_shot (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= ~btn_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev;

endmodule

// File: rtl/passcode_lock.sv
// Passcode lock: collects CODE_LEN digits per attempt, evaluates them only after
// the last digit, counts failures into a timed lockout, and allows code changes.
module passcode_lock
    import passcode_pkg::*;
#(
    parameter int DIGIT_W = 4,
    parameter int CODE_LEN = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1224,
    parameter int DIGIT_TIMEOUT = 1000000000,
    parameter int MAX_ATTEMPTS = 3,
    parameter int LOCKOUT_CYCLES = 1500000000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   btn_n,
    input  logic [DIGIT_W-1:0]                     SW,
    input  logic                                   program_en,
    output logic                                   unlocked,
    output logic                                   locked_out,
    output logic                                   fail,
    output logic [digit_count_w(CODE_LEN)-1:0]     digit_count,
    output logic [attempts_w(MAX_ATTEMPTS)-1:0]    attempts_left,
    output logic [1:0]                             lock_state
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int DC_W   = digit_count_w(CODE_LEN);
    localparam int ATT_W  = attempts_w(MAX_ATTEMPTS);
    localparam int TO_W   = count_w(DIGIT_TIMEOUT);
    localparam int LO_W   = count_w(LOCKOUT_CYCLES);

    localparam logic [DC_W-1:0]  LAST_DIGIT = DC_W'(CODE_LEN - 1);
    localparam logic [ATT_W-1:0] ATT_MAX    = ATT_W'(MAX_ATTEMPTS);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(DIGIT_TIMEOUT - 1);
    localparam logic [LO_W-1:0]  LO_LOAD    = LO_W'(LOCKOUT_CYCLES - 1);

    lock_state_t        state;
    logic [CODE_W-1:0]  code_reg;
    logic [CODE_W-1:0]  shadow;
    logic               mismatch_acc;
    logic [TO_W-1:0]    to_cnt;
    logic [LO_W-1:0]    lo_cnt;
    logic               press;
    logic [DIGIT_W-1:0] cur_digit;
    logic               digit_match;
    logic               in_sequence;
    logic               timeout_hit;

    btn_one_shot u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .press (press)
    );

    // Digit 0 lives in the MSBs of the code register.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_count == DC_W'(i)) begin
                cur_digit = code_reg[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_match = (SW == cur_digit);
    assign in_sequence = ((state == S_ENTRY) || (state == S_PROGRAM)) && (digit_count != '0);
    assign timeout_hit = in_sequence && (to_cnt == TO_LAST);
    assign lock_state  = state;

    // Idle counter between presses; a press always restarts it, even on the expiry cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (press || !in_sequence || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_ENTRY;
            unlocked      <= 1'b0;
            locked_out    <= 1'b0;
            fail          <= 1'b0;
            digit_count   <= '0;
            attempts_left <= ATT_MAX;
            code_reg      <= DEFAULT_CODE;
            shadow        <= '0;
            mismatch_acc  <= 1'b0;
            lo_cnt        <= '0;
        end else begin
            fail <= 1'b0;
            case (state)
                S_ENTRY: begin
                    if (press) begin
                        if (digit_count == LAST_DIGIT) begin
                            digit_count  <= '0;
                            mismatch_acc <= 1'b0;
                            if (!mismatch_acc && digit_match) begin
                                state         <= S_UNLOCKED;
                                unlocked      <= 1'b1;
                                attempts_left <= ATT_MAX;
                            end else begin
                                fail          <= 1'b1;
                                attempts_left <= attempts_left - ATT_W'(1);
                                if (attempts_left == ATT_W'(1)) begin
                                    state      <= S_LOCKOUT;
                                    locked_out <= 1'b1;
                                    lo_cnt     <= LO_LOAD;
                                end
                            end
                        end else begin
                            digit_count  <= digit_count + DC_W'(1);
                            mismatch_acc <= mismatch_acc | ~digit_match;
                        end
                    end else if (timeout_hit) begin
                        digit_count  <= '0;
                        mismatch_acc <= 1'b0;
                    end
                end

                S_PROGRAM: begin
                    if (press) begin
                        if (digit_count == LAST_DIGIT) begin
                            // Whole new code lands in one cycle, last digit taken straight from SW.
                            code_reg    <= {shadow[CODE_W-1:DIGIT_W], SW};
                            shadow      <= '0;
                            digit_count <= '0;
                            state       <= S_UNLOCKED;
                            unlocked    <= 1'b1;
                        end else begin
                            for (int i = 0; i < CODE_LEN; i++) begin
                                if (digit_count == DC_W'(i)) begin
                                    shadow[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] <= SW;
                                end
                            end
                            digit_count <= digit_count + DC_W'(1);
                        end
                    end else if (timeout_hit) begin
                        shadow      <= '0;
                        digit_count <= '0;
                        state       <= S_UNLOCKED;
                        unlocked    <= 1'b1;
                    end
                end

                S_UNLOCKED: begin
                    if (press) begin
                        unlocked    <= 1'b0;
                        digit_count <= '0;
                        state       <= program_en ? S_PROGRAM : S_ENTRY;
                    end
                end

                S_LOCKOUT: begin
                    if (lo_cnt == '0) begin
                        state         <= S_ENTRY;
                        locked_out    <= 1'b0;
                        attempts_left <= ATT_MAX;
                    end else begin
                        lo_cnt <= lo_cnt - LO_W'(1);
                    end
                end

                default: begin
                    state      <= S_ENTRY;
                    unlocked   <= 1'b0;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_passcode_lock.sv
// Randomized and directed bench for passcode_lock against a digit-queue reference model.
module tb_passcode_lock;

    localparam int DIGIT_W        = 4;
    localparam int CODE_LEN       = 4;
    localparam int DIGIT_TIMEOUT  = 100;
    localparam int MAX_ATTEMPTS   = 3;
    localparam int LOCKOUT_CYCLES = 50;
    localparam logic [15:0] DEFAULT_CODE = 16'h1224;

    localparam int ST_ENTRY    = 0;
    localparam int ST_UNLOCKED = 1;
    localparam int ST_PROGRAM  = 2;
    localparam int ST_LOCKOUT  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               btn_n;
    logic [DIGIT_W-1:0] SW;
    logic               program_en;
    logic               unlocked;
    logic               locked_out;
    logic               fail;
    logic [2:0]         digit_count;
    logic [1:0]         attempts_left;
    logic [1:0]         lock_state;

    passcode_lock #(
        .DIGIT_W        (DIGIT_W),
        .CODE_LEN       (CODE_LEN),
        .DEFAULT_CODE   (DEFAULT_CODE),
        .DIGIT_TIMEOUT  (DIGIT_TIMEOUT),
        .MAX_ATTEMPTS   (MAX_ATTEMPTS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .SW            (SW),
        .program_en    (program_en),
        .unlocked      (unlocked),
        .locked_out    (locked_out),
        .fail          (fail),
        .digit_count   (digit_count),
        .attempts_left (attempts_left),
        .lock_state    (lock_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: digits kept as queues, code as an array of digits.
    int                 m_state;
    logic [DIGIT_W-1:0] m_code [CODE_LEN];
    logic [DIGIT_W-1:0] m_entry[$];
    logic [DIGIT_W-1:0] m_shadow[$];
    int                 m_attempts;
    int                 m_idle;
    int                 m_lock_left;
    bit                 m_fail;
    bit                 s1, s2, s3;

    int         fail_seen;
    int         lock_run;
    int         dc_incs;
    logic [2:0] prev_dc;

    task automatic model_reset();
        logic [15:0] dflt;
        dflt = DEFAULT_CODE;
        m_state = ST_ENTRY;
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = 4'(dflt >> (4 * (CODE_LEN - 1 - i)));
        m_entry.delete();
        m_shadow.delete();
        m_attempts  = MAX_ATTEMPTS;
        m_idle      = 0;
        m_lock_left = 0;
        s1 = 1'b1;
        s2 = 1'b1;
        s3 = 1'b1;
    endtask

    function automatic bit code_ok();
        for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] !== m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: advance the model by the posedge just passed, then compare everything.
    task automatic step();
        bit                 pressed;
        bit                 cur_btn;
        bit                 pe_now;
        logic [DIGIT_W-1:0] sw_now;
        int                 dc_exp;
        logic [9:0]         exp_v;
        logic [9:0]         got_v;
        @(negedge clk);
        cur_btn = btn_n;
        sw_now  = SW;
        pe_now  = program_en;
        m_fail  = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            // A press is recognised two edges after the first edge that samples the button low.
            pressed = !s2 && s3;
            s3 = s2;
            s2 = s1;
            s1 = cur_btn;
            case (m_state)
                ST_ENTRY: begin
                    if (pressed) begin
                        m_entry.push_back(sw_now);
                        m_idle = 0;
                        if (m_entry.size() == CODE_LEN) begin
                            if (code_ok()) begin
                                m_state    = ST_UNLOCKED;
                                m_attempts = MAX_ATTEMPTS;
                            end else begin
                                m_fail = 1'b1;
                                m_attempts--;
                                if (m_attempts == 0) begin
                                    m_state     = ST_LOCKOUT;
                                    m_lock_left = LOCKOUT_CYCLES;
                                end
                            end
                            m_entry.delete();
                        end
                    end else if (m_entry.size() > 0) begin
                        m_idle++;
                        if (m_idle == DIGIT_TIMEOUT) begin
                            m_entry.delete();
                            m_idle = 0;
                        end
                    end
                end
                ST_PROGRAM: begin
                    if (pressed) begin
                        m_shadow.push_back(sw_now);
                        m_idle = 0;
                        if (m_shadow.size() == CODE_LEN) begin
                            for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_shadow[i];
                            m_shadow.delete();
                            m_state = ST_UNLOCKED;
                        end
                    end else if (m_shadow.size() > 0) begin
                        m_idle++;
                        if (m_idle == DIGIT_TIMEOUT) begin
                            m_shadow.delete();
                            m_idle  = 0;
                            m_state = ST_UNLOCKED;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (pressed) m_state = pe_now ? ST_PROGRAM : ST_ENTRY;
                    m_idle = 0;
                end
                default: begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin
                        m_state    = ST_ENTRY;
                        m_attempts = MAX_ATTEMPTS;
                    end
                end
            endcase
        end
        dc_exp = (m_state == ST_ENTRY) ? m_entry.size() :
                 (m_state == ST_PROGRAM) ? m_shadow.size() : 0;
        exp_v = {2'(m_state), (m_state == ST_UNLOCKED), (m_state == ST_LOCKOUT), m_fail,
                 3'(dc_exp), 2'(m_attempts)};
        got_v = {lock_state, unlocked, locked_out, fail, digit_count, attempts_left};
        check_eq("cycle", 32'(got_v), 32'(exp_v));
        if (fail === 1'b1) fail_seen++;
        if (lock_state === 2'd3) lock_run++;
        if (digit_count > prev_dc) dc_incs++;
        prev_dc = digit_count;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic [DIGIT_W-1:0] d, input bit pe, input int hold, input int gap);
        SW         = d;
        program_en = pe;
        btn_n      = 1'b0;
        repeat (hold) step();
        btn_n = 1'b1;
        repeat (gap) step();
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < CODE_LEN; i++) press(4'(c >> (12 - 4 * i)), 1'b0, 3, 2);
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        btn_n = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        bit                 good;
        logic [DIGIT_W-1:0] d;
        rst        = 1'b1;
        btn_n      = 1'b1;
        SW         = '0;
        program_en = 1'b0;
        prev_dc    = '0;
        fail_seen  = 0;
        lock_run   = 0;
        dc_incs    = 0;
        model_reset();
        do_reset(3);
        check_eq("reset_state", 32'(lock_state), 32'd0);
        check_eq("reset_attempts", 32'(attempts_left), 32'd3);
        check_eq("reset_digits", 32'(digit_count), 32'd0);

        // Correct entry with the default code.
        enter_code(16'h1224);
        check_eq("unlock_default", 32'(unlocked), 32'd1);
        check_eq("unlock_attempts", 32'(attempts_left), 32'd3);
        check_eq("unlock_no_fail", 32'(fail_seen), 32'd0);
        press(4'd0, 1'b0, 3, 2);

        // Hidden mismatch: nothing visible until the last digit.
        press(4'd1, 1'b0, 3, 2);
        press(4'd3, 1'b0, 3, 2);
        check_eq("hidden_state", 32'(lock_state), 32'd0);
        check_eq("hidden_no_fail", 32'(fail_seen), 32'd0);
        press(4'd2, 1'b0, 3, 2);
        press(4'd4, 1'b0, 3, 2);
        check_eq("hidden_fail_once", 32'(fail_seen), 32'd1);
        check_eq("hidden_attempts", 32'(attempts_left), 32'd2);
        check_eq("hidden_digits", 32'(digit_count), 32'd0);

        // Lockout after the remaining attempts are used up.
        enter_code(16'h9999);
        lock_run = 0;
        enter_code(16'h9999);
        check_eq("lockout_flag", 32'(locked_out), 32'd1);
        check_eq("lockout_attempts", 32'(attempts_left), 32'd0);
        press(4'd1, 1'b0, 3, 2);
        check_eq("lockout_ignores_press", 32'(locked_out), 32'd1);
        check_eq("lockout_press_digits", 32'(digit_count), 32'd0);
        idle(60);
        check_eq("lockout_duration", 32'(lock_run), 32'd50);
        check_eq("lockout_exit_state", 32'(lock_state), 32'd0);
        check_eq("lockout_exit_attempts", 32'(attempts_left), 32'd3);

        // Inter-digit timeout.
        fail_seen = 0;
        press(4'd1, 1'b0, 3, 2);
        press(4'd2, 1'b0, 3, 1);
        idle(98);
        check_eq("timeout_not_early", 32'(digit_count), 32'd2);
        idle(1);
        check_eq("timeout_digits", 32'(digit_count), 32'd0);
        check_eq("timeout_attempts", 32'(attempts_left), 32'd3);
        check_eq("timeout_no_fail", 32'(fail_seen), 32'd0);
        enter_code(16'h1224);
        check_eq("unlock_after_timeout", 32'(unlocked), 32'd1);

        // Code change, relock, old code fails, new code opens, reset restores default.
        press(4'd0, 1'b1, 3, 2);
        check_eq("program_state", 32'(lock_state), 32'd2);
        enter_code(16'h7701);
        check_eq("program_done", 32'(unlocked), 32'd1);
        press(4'd0, 1'b0, 3, 2);
        fail_seen = 0;
        enter_code(16'h1224);
        check_eq("old_code_fails", 32'(fail_seen), 32'd1);
        check_eq("old_code_attempts", 32'(attempts_left), 32'd2);
        enter_code(16'h7701);
        check_eq("new_code_unlocks", 32'(unlocked), 32'd1);
        do_reset(2);
        enter_code(16'h1224);
        check_eq("reset_restores_code", 32'(unlocked), 32'd1);
        press(4'd0, 1'b0, 3, 2);

        // Long hold gives exactly one digit.
        dc_incs = 0;
        press(4'd5, 1'b0, 500, 2);
        check_eq("hold_one_digit", 32'(dc_incs), 32'd1);

        // Press landing on the timeout cycle is taken.
        press(4'd1, 1'b0, 3, 97);
        press(4'd2, 1'b0, 3, 1);
        check_eq("press_beats_timeout", 32'(digit_count), 32'd2);
        idle(100);

        // Reset mid-sequence drops partial input.
        press(4'd1, 1'b0, 3, 2);
        press(4'd2, 1'b0, 3, 2);
        press(4'd2, 1'b0, 3, 2);
        check_eq("pre_reset_digits", 32'(digit_count), 32'd3);
        do_reset(1);
        check_eq("reset_mid_digits", 32'(digit_count), 32'd0);

        // Randomized traffic against the model.
        good = 1'b0;
        for (int n = 0; n < 250; n++) begin
            if (m_state == ST_ENTRY && m_entry.size() == 0) good = ($urandom_range(0, 1) == 1);
            if (good && m_state == ST_ENTRY && m_entry.size() < CODE_LEN) d = m_code[m_entry.size()];
            else d = 4'($urandom_range(0, 15));
            press(d, 1'($urandom_range(0, 1)), $urandom_range(1, 6),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(95, 105) : $urandom_range(1, 8));
            if ($urandom_range(0, 99) == 0) do_reset(1);
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
